// File: rtl/axi_pkg.sv
// Shared AXI4 types for the memory responder: burst encodings, response codes
// and the responder FSM state.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WDATA = 2'b01,
    ST_WRESP = 2'b10,
    ST_RDATA = 2'b11
  } state_t;

endpackage

// File: rtl/bram_be.sv
// Single-port DEPTH x 32 memory with per-byte write enables and a registered
// read port. The array itself is never reset, so contents survive rst_i.
module bram_be #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (we_i[b]) begin
          mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // The read register only loads on a read access, so it holds through R stalls.
  always_comb begin
    rdata_d = rdata_q;
    if (en_i && (we_i == 4'b0000)) begin
      rdata_d = mem[addr_i];
    end else begin
      rdata_d = rdata_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= 32'h0000_0000;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 memory responder: one read or write transaction in flight, round-robin
// between AW and AR when both request in the same idle cycle.
module axi_mem_slave
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 27,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int DEPTH      = 4096
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awlock,
  input  logic [3:0]            s_axi_awcache,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            beat_q, beat_d;
  logic [7:0]            beat_nxt;
  burst_t                burst_q, burst_d;
  logic                  prio_rd_q, prio_rd_d;
  logic                  bvalid_q, bvalid_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;

  logic                  grant_w;
  logic                  grant_r;
  logic                  mem_en;
  logic [3:0]            mem_we;
  logic [IDX_W-1:0]      mem_idx;

  logic                  unused_inputs;
  assign unused_inputs = ^{s_axi_awsize, s_axi_awlock, s_axi_awcache, s_axi_awprot,
                           s_axi_arsize, s_axi_arlock, s_axi_arcache, s_axi_arprot,
                           s_axi_wlast};

  // Transfer size is ignored: every beat is one 32-bit word; WRAP behaves as INCR.
  function automatic logic [ADDR_WIDTH-1:0] step_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input burst_t b);
    case (b)
      BURST_FIXED: step_addr = a;
      default:     step_addr = a + ADDR_WIDTH'(4);
    endcase
  endfunction

  // prio_rd_q flips to whichever channel was not served last; write wins after reset.
  assign grant_w  = !rst_i && s_axi_awvalid && (!s_axi_arvalid || !prio_rd_q);
  assign grant_r  = !rst_i && s_axi_arvalid && (!s_axi_awvalid ||  prio_rd_q);
  assign beat_nxt = beat_q + 8'd1;

  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    addr_d        = addr_q;
    len_d         = len_q;
    beat_d        = beat_q;
    burst_d       = burst_q;
    prio_rd_d     = prio_rd_q;
    bvalid_d      = bvalid_q;
    rvalid_d      = rvalid_q;
    rlast_d       = rlast_q;
    mem_en        = 1'b0;
    mem_we        = 4'b0000;
    mem_idx       = addr_q[IDX_W+1:2];
    s_axi_awready = 1'b0;
    s_axi_arready = 1'b0;
    s_axi_wready  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_w) begin
          s_axi_awready = 1'b1;
          id_d          = s_axi_awid;
          addr_d        = s_axi_awaddr;
          len_d         = s_axi_awlen;
          burst_d       = burst_t'(s_axi_awburst);
          beat_d        = 8'd0;
          prio_rd_d     = 1'b1;
          state_d       = ST_WDATA;
        end else if (grant_r) begin
          // First beat is fetched during the handshake so rvalid rises next cycle.
          s_axi_arready = 1'b1;
          id_d          = s_axi_arid;
          len_d         = s_axi_arlen;
          burst_d       = burst_t'(s_axi_arburst);
          beat_d        = 8'd0;
          prio_rd_d     = 1'b0;
          mem_en        = 1'b1;
          mem_idx       = s_axi_araddr[IDX_W+1:2];
          addr_d        = step_addr(s_axi_araddr, burst_t'(s_axi_arburst));
          rvalid_d      = 1'b1;
          rlast_d       = (s_axi_arlen == 8'd0);
          state_d       = ST_RDATA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WDATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid) begin
          mem_en = 1'b1;
          mem_we = s_axi_wstrb;
          addr_d = step_addr(addr_q, burst_q);
          beat_d = beat_nxt;
          // Burst length comes from awlen alone; wlast is not trusted.
          if (beat_q == len_q) begin
            bvalid_d = 1'b1;
            state_d  = ST_WRESP;
          end else begin
            state_d = ST_WDATA;
          end
        end else begin
          state_d = ST_WDATA;
        end
      end
      ST_WRESP: begin
        if (s_axi_bready) begin
          bvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_WRESP;
        end
      end
      ST_RDATA: begin
        if (s_axi_rready) begin
          if (rlast_q) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            mem_en  = 1'b1;
            mem_idx = addr_q[IDX_W+1:2];
            addr_d  = step_addr(addr_q, burst_q);
            beat_d  = beat_nxt;
            rlast_d = (beat_nxt == len_q);
            state_d = ST_RDATA;
          end
        end else begin
          state_d = ST_RDATA;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= 8'd0;
      beat_q    <= 8'd0;
      burst_q   <= BURST_FIXED;
      prio_rd_q <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      burst_q   <= burst_d;
      prio_rd_q <= prio_rd_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
    end
  end

  bram_be #(.DEPTH(DEPTH)) u_mem (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (mem_en),
    .we_i    (mem_we),
    .addr_i  (mem_idx),
    .wdata_i (s_axi_wdata),
    .rdata_o (s_axi_rdata)
  );

  assign s_axi_bid    = id_q;
  assign s_axi_bresp  = RESP_OKAY;
  assign s_axi_bvalid = bvalid_q;
  assign s_axi_rid    = id_q;
  assign s_axi_rresp  = RESP_OKAY;
  assign s_axi_rlast  = rlast_q;
  assign s_axi_rvalid = rvalid_q;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed and randomized bench for axi_mem_slave against a word-array memory
// model addressed by (addr/4 + beat) mod DEPTH.
module tb_axi_mem_slave;

  localparam int DEPTH = 4096;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  s_axi_awid = 8'd0;
  logic [26:0] s_axi_awaddr = 27'd0;
  logic [7:0]  s_axi_awlen = 8'd0;
  logic [2:0]  s_axi_awsize = 3'd2;
  logic [1:0]  s_axi_awburst = 2'd1;
  logic        s_axi_awlock = 1'b0;
  logic [3:0]  s_axi_awcache = 4'd0;
  logic [2:0]  s_axi_awprot = 3'd0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = 32'd0;
  logic [3:0]  s_axi_wstrb = 4'd0;
  logic        s_axi_wlast = 1'b0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [7:0]  s_axi_bid;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [7:0]  s_axi_arid = 8'd0;
  logic [26:0] s_axi_araddr = 27'd0;
  logic [7:0]  s_axi_arlen = 8'd0;
  logic [2:0]  s_axi_arsize = 3'd2;
  logic [1:0]  s_axi_arburst = 2'd1;
  logic        s_axi_arlock = 1'b0;
  logic [3:0]  s_axi_arcache = 4'd0;
  logic [2:0]  s_axi_arprot = 3'd0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [7:0]  s_axi_rid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] wdata_tab [16];
  logic [3:0]  wstrb_tab [16];
  int n_checks = 0;
  int n_errors = 0;

  axi_mem_slave #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
    .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
    .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [26:0] a, input logic [1:0] b, input int i);
    int base;
    base = int'(a >> 2);
    return (b == 2'b00) ? (base % DEPTH) : ((base + i) % DEPTH);
  endfunction

  task automatic model_wr(input logic [26:0] a, input logic [1:0] b, input int i,
                          input logic [31:0] d, input logic [3:0] s);
    int k;
    k = widx(a, b, i);
    for (int j = 0; j < 4; j++) if (s[j]) model_mem[k][8*j +: 8] = d[8*j +: 8];
  endtask

  task automatic aw_send(input logic [26:0] a, input logic [7:0] len, input logic [1:0] b,
                         input logic [7:0] id);
    bit got;
    got = 1'b0;
    s_axi_awaddr = a; s_axi_awlen = len; s_axi_awburst = b; s_axi_awid = id;
    s_axi_awvalid = 1'b1;
    for (int c = 0; c < 64 && !got; c++) begin @(negedge clk_i); got = s_axi_awready; end
    check("aw_handshake", got, 1'b1);
    if (got) begin @(posedge clk_i); #1; end
    s_axi_awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s, input logic last);
    bit got;
    got = 1'b0;
    s_axi_wdata = d; s_axi_wstrb = s; s_axi_wlast = last; s_axi_wvalid = 1'b1;
    for (int c = 0; c < 64 && !got; c++) begin @(negedge clk_i); got = s_axi_wready; end
    check("w_handshake", got, 1'b1);
    if (got) begin @(posedge clk_i); #1; end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
  endtask

  task automatic b_recv(input logic [7:0] id, input int delay);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 64 && !got; c++) begin @(negedge clk_i); got = s_axi_bvalid; end
    check("b_valid_wait", got, 1'b1);
    for (int d = 0; d < delay; d++) begin
      check("b_hold", s_axi_bvalid, 1'b1);
      @(negedge clk_i);
    end
    s_axi_bready = 1'b1;
    check("b_valid", s_axi_bvalid, 1'b1);
    check("b_id", s_axi_bid, id);
    check("b_resp", s_axi_bresp, 2'b00);
    @(posedge clk_i); #1;
    s_axi_bready = 1'b0;
  endtask

  task automatic ar_send(input logic [26:0] a, input logic [7:0] len, input logic [1:0] b,
                         input logic [7:0] id);
    bit got;
    got = 1'b0;
    s_axi_araddr = a; s_axi_arlen = len; s_axi_arburst = b; s_axi_arid = id;
    s_axi_arvalid = 1'b1;
    for (int c = 0; c < 64 && !got; c++) begin @(negedge clk_i); got = s_axi_arready; end
    check("ar_handshake", got, 1'b1);
    if (got) begin @(posedge clk_i); #1; end
    s_axi_arvalid = 1'b0;
  endtask

  // Called right after the AR handshake edge; stall cycles re-check the same beat.
  task automatic r_recv(input logic [26:0] a, input logic [7:0] len, input logic [1:0] b,
                        input logic [7:0] id, input bit toggle, input int stop);
    int i;
    int cyc;
    int nbeats;
    i = 0; cyc = 0;
    nbeats = (int'(len) + 1 < stop) ? int'(len) + 1 : stop;
    while (i < nbeats && cyc < 200) begin
      s_axi_rready = toggle ? (cyc % 2 == 0) : 1'b1;
      @(negedge clk_i);
      if (cyc == 0) check("r_latency", s_axi_rvalid, 1'b1);
      if (s_axi_rvalid) begin
        check("r_data", s_axi_rdata, model_mem[widx(a, b, i)]);
        check("r_last", s_axi_rlast, (i == int'(len)));
        check("r_id", s_axi_rid, id);
        check("r_resp", s_axi_rresp, 2'b00);
        if (s_axi_rready) i++;
      end
      @(posedge clk_i); #1;
      cyc++;
    end
    s_axi_rready = 1'b0;
    check("r_beats", i, nbeats);
  endtask

  task automatic axi_write(input logic [26:0] a, input logic [7:0] len, input logic [1:0] b,
                           input logic [7:0] id, input int early, input int bdelay);
    aw_send(a, len, b, id);
    for (int i = 0; i <= int'(len); i++) begin
      w_send(wdata_tab[i], wstrb_tab[i], (early >= 0) ? (i == early) : (i == int'(len)));
      model_wr(a, b, i, wdata_tab[i], wstrb_tab[i]);
    end
    b_recv(id, bdelay);
  endtask

  task automatic axi_read(input logic [26:0] a, input logic [7:0] len, input logic [1:0] b,
                          input logic [7:0] id, input bit toggle);
    ar_send(a, len, b, id);
    r_recv(a, len, b, id, toggle, 256);
    @(negedge clk_i);
    check("r_idle_after", s_axi_rvalid, 1'b0);
    @(posedge clk_i); #1;
  endtask

  task automatic fill_random(input bit rand_strb);
    for (int i = 0; i < 16; i++) begin
      wdata_tab[i] = $urandom;
      wstrb_tab[i] = rand_strb ? 4'($urandom_range(0, 15)) : 4'hF;
    end
  endtask

  initial begin
    logic [26:0] ra;
    logic [7:0]  rl;
    logic [1:0]  rb;

    // Reset state, with both address channels requesting
    s_axi_awvalid = 1'b1; s_axi_arvalid = 1'b1; s_axi_wvalid = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_awready", s_axi_awready, 1'b0);
    check("rst_arready", s_axi_arready, 1'b0);
    check("rst_wready", s_axi_wready, 1'b0);
    check("rst_bvalid", s_axi_bvalid, 1'b0);
    check("rst_rvalid", s_axi_rvalid, 1'b0);
    check("rst_outs", {s_axi_rdata, s_axi_rid, s_axi_bid, s_axi_rresp, s_axi_bresp, s_axi_rlast},
          64'd0);
    s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0; s_axi_wvalid = 1'b0;
    @(posedge clk_i); #1; rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Single write then read
    wdata_tab[0] = 32'hDEADBEEF; wstrb_tab[0] = 4'hF;
    axi_write(27'h100, 8'd0, 2'b01, 8'h5A, -1, 0);
    axi_read(27'h100, 8'd0, 2'b01, 8'hC3, 1'b0);

    // Byte strobes over a pre-filled word
    wdata_tab[0] = 32'hFFFFFFFF; wstrb_tab[0] = 4'hF;
    axi_write(27'h200, 8'd0, 2'b01, 8'h01, -1, 0);
    wdata_tab[0] = 32'h11223344; wstrb_tab[0] = 4'b0101;
    axi_write(27'h200, 8'd0, 2'b01, 8'h02, -1, 0);
    axi_read(27'h200, 8'd0, 2'b01, 8'h03, 1'b0);

    // INCR burst of 8 with a stalling reader
    for (int i = 0; i < 16; i++) begin wdata_tab[i] = 32'(i); wstrb_tab[i] = 4'hF; end
    axi_write(27'h0, 8'd7, 2'b01, 8'h10, -1, 0);
    axi_read(27'h0, 8'd7, 2'b01, 8'h11, 1'b1);

    // Early wlast must not cut the burst short
    fill_random(1'b0);
    axi_write(27'h600, 8'd3, 2'b01, 8'h20, 1, 0);
    axi_read(27'h600, 8'd3, 2'b01, 8'h21, 1'b0);

    // FIXED bursts hit one word; WRAP steps like INCR
    fill_random(1'b0);
    axi_write(27'h700, 8'd3, 2'b00, 8'h30, -1, 0);
    axi_read(27'h700, 8'd2, 2'b00, 8'h31, 1'b0);
    axi_read(27'h6FC, 8'd2, 2'b01, 8'h32, 1'b0);
    fill_random(1'b0);
    axi_write(27'h900, 8'd3, 2'b10, 8'h33, -1, 0);
    axi_read(27'h900, 8'd3, 2'b01, 8'h34, 1'b1);

    // Address wraps modulo DEPTH words
    wdata_tab[0] = 32'hA5A5A5A5; wstrb_tab[0] = 4'hF;
    axi_write(27'h4000, 8'd0, 2'b01, 8'h40, -1, 0);
    axi_read(27'h0, 8'd0, 2'b01, 8'h41, 1'b0);

    // Random traffic: full-strobe fill, then random-strobe overwrite, then readback
    for (int t = 0; t < 12; t++) begin
      ra = 27'($urandom) & 27'h7FFFFFC;
      rl = 8'($urandom_range(0, 7));
      rb = 2'($urandom_range(0, 2));
      fill_random(1'b0);
      axi_write(ra, rl, rb, 8'($urandom), -1, 0);
      fill_random(1'b1);
      axi_write(ra, rl, rb, 8'($urandom), -1, $urandom_range(0, 2));
      axi_read(ra, rl, rb, 8'($urandom), 1'($urandom_range(0, 1)));
    end

    // Reset during beat 3 of a len-7 read
    fill_random(1'b0);
    axi_write(27'h800, 8'd7, 2'b01, 8'h50, -1, 0);
    ar_send(27'h800, 8'd7, 2'b01, 8'h51);
    r_recv(27'h800, 8'd7, 2'b01, 8'h51, 1'b0, 3);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("midrst_rvalid", s_axi_rvalid, 1'b0);
    check("midrst_outs", {s_axi_rdata, s_axi_rlast, s_axi_rid}, 41'd0);
    @(posedge clk_i); #1; rst_i = 1'b0;
    @(negedge clk_i);
    check("postrst_rvalid", s_axi_rvalid, 1'b0);
    check("postrst_bvalid", s_axi_bvalid, 1'b0);
    @(posedge clk_i); #1;
    axi_read(27'h800, 8'd7, 2'b01, 8'h52, 1'b0);
    axi_read(27'h200, 8'd0, 2'b01, 8'h53, 1'b0);

    // Last grant is a write, then reset: write must still win first afterwards
    fill_random(1'b0);
    axi_write(27'hA00, 8'd0, 2'b01, 8'h60, -1, 0);
    rst_i = 1'b1;
    @(posedge clk_i); #1; rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Both channels held valid across three grants: W, R, W
    fill_random(1'b0);
    s_axi_awaddr = 27'h500; s_axi_awlen = 8'd0; s_axi_awburst = 2'b01; s_axi_awid = 8'h21;
    s_axi_araddr = 27'h100; s_axi_arlen = 8'd0; s_axi_arburst = 2'b01; s_axi_arid = 8'h31;
    s_axi_awvalid = 1'b1; s_axi_arvalid = 1'b1;
    @(negedge clk_i);
    check("arb1_awready", s_axi_awready, 1'b1);
    check("arb1_arready", s_axi_arready, 1'b0);
    @(posedge clk_i); #1;
    w_send(wdata_tab[0], 4'hF, 1'b1);
    model_wr(27'h500, 2'b01, 0, wdata_tab[0], 4'hF);
    b_recv(8'h21, 5);
    @(negedge clk_i);
    check("arb2_arready", s_axi_arready, 1'b1);
    check("arb2_awready", s_axi_awready, 1'b0);
    @(posedge clk_i); #1;
    r_recv(27'h100, 8'd0, 2'b01, 8'h31, 1'b0, 256);
    @(negedge clk_i);
    check("arb3_awready", s_axi_awready, 1'b1);
    check("arb3_arready", s_axi_arready, 1'b0);
    @(posedge clk_i); #1;
    s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
    w_send(wdata_tab[1], 4'hF, 1'b1);
    model_wr(27'h500, 2'b01, 0, wdata_tab[1], 4'hF);
    b_recv(8'h21, 0);
    axi_read(27'h500, 8'd0, 2'b01, 8'h70, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
